// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register writeback queue: default widths,
// the queued entry layout and the width rule for the occupancy counter.
package reg_wb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 4;

    // One pending register write: destination index plus result data.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dst;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    // The counter must hold 0..DEPTH. It normally matches the register index
    // width plus one, and only grows when the queue is deeper than the file.
    function automatic int count_width(input int depth, input int addr_w);
        int lg;
        lg = $clog2(depth);
        return (lg > addr_w) ? lg + 1 : addr_w + 1;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Circular storage for pending register writes. Exposes the occupancy and an
// age-ordered view of every slot (index 0 = head/oldest) so the parent can
// run its forwarding lookups without knowing about pointer positions.
module wb_queue
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = count_width(DEPTH_DEF, ADDR_W_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              ord_valid [DEPTH],
    output logic [ADDR_W-1:0] ord_reg   [DEPTH],
    output logic [DATA_W-1:0] ord_data  [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Never write into a full queue or pop an empty one, whatever the parent asks.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping; reset discards every pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; slots are only ever read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr]  <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Rotate storage into age order: slot g is the g-th oldest pending write.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ord
        logic [PTR_W-1:0] idx;
        assign idx          = rd_ptr + PTR_W'(g);
        assign ord_valid[g] = (CNT_W'(g) < cnt);
        assign ord_reg[g]   = mem_reg[idx];
        assign ord_data[g]  = mem_data[idx];
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback buffer in front of the register file write port. Accepts results
// from execute, drains them one per cycle in strict FIFO order, and lets two
// operand-fetch ports see the youngest not-yet-committed value of a register.
// Build option WB_R0_ZERO_EN: writes to register 0 are consumed and dropped,
// and register 0 never produces a lookup hit.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready
// are both high; in_ready depends only on queue occupancy (never on in_valid),
// and in_reg/in_data must be held stable while in_valid waits for in_ready.
module reg_writeback_queue
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ADDR_W-1:0]                    in_reg,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic                                 wb_stall,
    output logic                                 reg_write,
    output logic [ADDR_W-1:0]                    write_reg,
    output logic [DATA_W-1:0]                    write_data,
    input  logic [ADDR_W-1:0]                    lk1_reg,
    output logic                                 lk1_hit,
    output logic [DATA_W-1:0]                    lk1_data,
    input  logic [ADDR_W-1:0]                    lk2_reg,
    output logic                                 lk2_hit,
    output logic [DATA_W-1:0]                    lk2_data,
    output logic [count_width(DEPTH, ADDR_W)-1:0] count
);

    localparam int CNT_W = count_width(DEPTH, ADDR_W);

    logic              q_full;
    logic              q_empty;
    logic              accept;
    logic              is_r0;
    logic              push;
    logic              pop;
    logic              ord_valid [DEPTH];
    logic [ADDR_W-1:0] ord_reg   [DEPTH];
    logic [DATA_W-1:0] ord_data  [DEPTH];
    logic [ADDR_W-1:0] lk_reg    [2];

    // No pass-through: a full queue refuses input even if the head drains this cycle.
    assign in_ready = ~q_full;
    assign accept   = in_valid & in_ready;

`ifdef WB_R0_ZERO_EN
    // Register 0 is hardwired to zero, so its writes are swallowed after the handshake.
    assign is_r0 = (in_reg == '0);
`else
    assign is_r0 = 1'b0;
`endif

    assign push = accept & ~is_r0;

    // The file always accepts, so the head commits on every unstalled cycle.
    assign pop        = ~q_empty & ~wb_stall;
    assign reg_write  = pop;
    assign write_reg  = ord_reg[0];
    assign write_data = ord_data[0];

    wb_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (in_reg),
        .push_data (in_data),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .count     (count),
        .ord_valid (ord_valid),
        .ord_reg   (ord_reg),
        .ord_data  (ord_data)
    );

    assign lk_reg[0] = lk1_reg;
    assign lk_reg[1] = lk2_reg;

    // One lookup per read port. Entries are scanned oldest to youngest so the
    // last match wins; the head is included even while it is being written,
    // and the request on the input this cycle is not yet an entry.
    for (genvar p = 0; p < 2; p++) begin : g_lk
        logic              hit;
        logic [DATA_W-1:0] data;

        // Youngest-match search over the valid entries for this port.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (ord_valid[i] && (ord_reg[i] == lk_reg[p])) begin
                    hit  = 1'b1;
                    data = ord_data[i];
                end
            end
`ifdef WB_R0_ZERO_EN
            if (lk_reg[p] == '0) begin
                hit  = 1'b0;
                data = '0;
            end
`endif
        end
    end

    assign lk1_hit  = g_lk[0].hit;
    assign lk1_data = g_lk[0].data;
    assign lk2_hit  = g_lk[1].hit;
    assign lk2_data = g_lk[1].data;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue. Inputs change 1 ns after the rising
// edge; outputs are checked a few ns later or on the falling edge. A falling
// edge monitor checks every committed write against the expected queue.
// Build with WB_R0_ZERO_EN defined to exercise the register-0 filter.
module tb_reg_writeback_queue;
    import reg_wb_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              wb_stall;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] lk1_reg;
    logic              lk1_hit;
    logic [DATA_W-1:0] lk1_data;
    logic [ADDR_W-1:0] lk2_reg;
    logic              lk2_hit;
    logic [DATA_W-1:0] lk2_data;
    logic [ADDR_W:0]   count;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_w;

    reg_writeback_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .wb_stall   (wb_stall),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .lk1_reg    (lk1_reg),
        .lk1_hit    (lk1_hit),
        .lk1_data   (lk1_data),
        .lk2_reg    (lk2_reg),
        .lk2_hit    (lk2_hit),
        .lk2_data   (lk2_data),
        .count      (count)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: every committed write must be the next expected entry.
    always @(negedge clk) begin
        if (!rst && reg_write) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_write: got r%0d=%h, expected no write", write_reg, write_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({write_reg, write_data} !== exp_w) begin
                    bad++;
                    $display("FAIL sb_write: got r%0d=%h, expected r%0d=%h",
                             write_reg, write_data, exp_w[EW-1:DATA_W], exp_w[DATA_W-1:0]);
                end
            end
        end
    end

    // Driver: advance to 1 ns after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver: offer one request for one cycle; records it as expected if taken.
    task automatic drive_push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                              output logic acc);
        logic filt;
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        @(negedge clk);
        acc = in_ready;
        cycle();
        in_valid = 1'b0;
`ifdef WB_R0_ZERO_EN
        filt = (r == '0);
`else
        filt = 1'b0;
`endif
        if (acc && !filt) exp_q.push_back({r, d});
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        wb_stall = 1'b0;
        lk1_reg  = 3'd0;
        lk2_reg  = 3'd1;
        repeat (2) cycle();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d, expected 0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL rst_reg_write: got %b, expected 0", reg_write); end
        total++; if (lk1_hit !== 1'b0 || lk2_hit !== 1'b0) begin bad++; $display("FAIL rst_lk_hit: got %b%b, expected 00", lk1_hit, lk2_hit); end
        rst = 1'b0;
        cycle();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL post_rst_count: got %0d, expected 0", count); end
    endtask

    task automatic test_single_write();
        wb_stall = 1'b0;
        lk1_reg  = 3'd3;
        in_valid = 1'b1;
        in_reg   = 3'd3;
        in_data  = 8'h5A;
        #1;
        total++; if (lk1_hit !== 1'b0) begin bad++; $display("FAIL inflight_lk: got %b, expected 0", lk1_hit); end
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL single_early_write: got %b, expected 0", reg_write); end
        cycle();
        in_valid = 1'b0;
        exp_q.push_back({3'd3, 8'h5A});
        #1;
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL single_reg_write: got %b, expected 1", reg_write); end
        total++; if (write_reg !== 3'd3) begin bad++; $display("FAIL single_write_reg: got %0d, expected 3", write_reg); end
        total++; if (write_data !== 8'h5A) begin bad++; $display("FAIL single_write_data: got %h, expected 5a", write_data); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count1: got %0d, expected 1", count); end
        total++; if (lk1_hit !== 1'b1 || lk1_data !== 8'h5A) begin bad++; $display("FAIL head_lk: got %b/%h, expected 1/5a", lk1_hit, lk1_data); end
        cycle();
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL single_count0: got %0d, expected 0", count); end
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL single_idle: got %b, expected 0", reg_write); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_drained: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_stall_full();
        logic acc;
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_push(ADDR_W'(i), 8'hA0 + DATA_W'(i), acc);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL fill_accept%0d: got %b, expected 1", i, acc); end
        end
        #1;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL full_count: got %0d, expected 4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b, expected 0", in_ready); end
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL stalled_write: got %b, expected 0", reg_write); end
        drive_push(3'd5, 8'hA5, acc);
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL full_reject: got %b, expected 0", acc); end
        total++; if (count !== 4'd4) begin bad++; $display("FAIL full_hold: got %0d, expected 4", count); end
        wb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (reg_write !== 1'b1 || count !== 4'(4 - i)) begin
                bad++; $display("FAIL drain%0d: got we=%b count=%0d, expected we=1 count=%0d", i, reg_write, count, 4 - i);
            end
            cycle();
        end
        #1;
        total++; if (count !== 4'd0 || exp_q.size() != 0) begin bad++; $display("FAIL drain_done: got count=%0d left=%0d, expected 0/0", count, exp_q.size()); end
    endtask

    task automatic test_lookup();
        logic acc;
        wb_stall = 1'b1;
        drive_push(3'd2, 8'h11, acc);
        drive_push(3'd2, 8'h22, acc);
        lk1_reg = 3'd2;
        lk2_reg = 3'd5;
        #1;
        total++; if (lk1_hit !== 1'b1 || lk1_data !== 8'h22) begin bad++; $display("FAIL lk1_youngest: got %b/%h, expected 1/22", lk1_hit, lk1_data); end
        total++; if (lk2_hit !== 1'b0 || lk2_data !== 8'h00) begin bad++; $display("FAIL lk2_miss: got %b/%h, expected 0/00", lk2_hit, lk2_data); end
        total++; if (write_data !== 8'h11) begin bad++; $display("FAIL lk_head: got %h, expected 11", write_data); end
        wb_stall = 1'b0;
        #1;
        total++; if (reg_write !== 1'b1 || lk1_data !== 8'h22) begin bad++; $display("FAIL lk_during_drain: got we=%b data=%h, expected 1/22", reg_write, lk1_data); end
        cycle();
        #1;
        total++; if (count !== 4'd1 || lk1_hit !== 1'b1 || write_data !== 8'h22) begin
            bad++; $display("FAIL lk_one_left: got count=%0d hit=%b head=%h, expected 1/1/22", count, lk1_hit, write_data);
        end
        cycle();
        #1;
        total++; if (lk1_hit !== 1'b0 || lk1_data !== 8'h00) begin bad++; $display("FAIL lk_empty: got %b/%h, expected 0/00", lk1_hit, lk1_data); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        wb_stall = 1'b1;
        drive_push(3'd1, 8'h10, acc);
        drive_push(3'd2, 8'h20, acc);
        for (int i = 0; i < 14; i++) begin
            wb_stall = 1'b0;
            in_valid = 1'b1;
            in_reg   = ADDR_W'((i % 7) + 1);
            in_data  = 8'h30 + DATA_W'(i);
            #1;
            total++; if (count !== 4'd2 || in_ready !== 1'b1 || reg_write !== 1'b1) begin
                bad++; $display("FAIL b2b%0d: got count=%0d rdy=%b we=%b, expected 2/1/1", i, count, in_ready, reg_write);
            end
            cycle();
            exp_q.push_back({ADDR_W'((i % 7) + 1), 8'h30 + DATA_W'(i)});
        end
        in_valid = 1'b0;
        repeat (2) cycle();
        #1;
        total++; if (count !== 4'd0 || exp_q.size() != 0) begin bad++; $display("FAIL b2b_done: got count=%0d left=%0d, expected 0/0", count, exp_q.size()); end
    endtask

    task automatic test_reset_mid_drain();
        logic acc;
        wb_stall = 1'b1;
        drive_push(3'd5, 8'h51, acc);
        drive_push(3'd6, 8'h62, acc);
        drive_push(3'd7, 8'h73, acc);
        lk1_reg = 3'd5;
        #1;
        total++; if (count !== 4'd3) begin bad++; $display("FAIL pre_rst_count: got %0d, expected 3", count); end
        wb_stall = 1'b0;
        #1;
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL pre_rst_write: got %b, expected 1", reg_write); end
        rst = 1'b1;
        #1;
        exp_q.delete();
        total++; if (reg_write !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL rst_now: got we=%b count=%0d, expected 0/0", reg_write, count); end
        total++; if (in_ready !== 1'b1 || lk1_hit !== 1'b0) begin bad++; $display("FAIL rst_now_flags: got rdy=%b hit=%b, expected 1/0", in_ready, lk1_hit); end
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            total++; if (reg_write !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL post_rst%0d: got we=%b count=%0d, expected 0/0", i, reg_write, count); end
        end
    endtask

    task automatic test_r0();
        logic acc;
        wb_stall = 1'b0;
        lk1_reg  = 3'd0;
        drive_push(3'd0, 8'hFF, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL r0_accept: got %b, expected 1", acc); end
        #1;
`ifdef WB_R0_ZERO_EN
        total++; if (count !== 4'd0 || reg_write !== 1'b0) begin bad++; $display("FAIL r0_dropped: got count=%0d we=%b, expected 0/0", count, reg_write); end
        total++; if (lk1_hit !== 1'b0 || lk1_data !== 8'h00) begin bad++; $display("FAIL r0_lk: got %b/%h, expected 0/00", lk1_hit, lk1_data); end
`else
        total++; if (count !== 4'd1 || reg_write !== 1'b1 || write_reg !== 3'd0 || write_data !== 8'hFF) begin
            bad++; $display("FAIL r0_write: got count=%0d we=%b r%0d=%h, expected 1/1/r0=ff", count, reg_write, write_reg, write_data);
        end
        total++; if (lk1_hit !== 1'b1 || lk1_data !== 8'hFF) begin bad++; $display("FAIL r0_lk: got %b/%h, expected 1/ff", lk1_hit, lk1_data); end
`endif
        cycle();
        #1;
        total++; if (count !== 4'd0 || exp_q.size() != 0) begin bad++; $display("FAIL r0_done: got count=%0d left=%0d, expected 0/0", count, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall_full();
        test_lookup();
        test_back_to_back();
        test_reset_mid_drain();
        test_r0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
